// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one UART transmitter between up to four byte producers. Pending
// requesters are served round-robin. Each granted payload byte can be
// preceded by a header byte (HEADER_BASE | owner) that identifies the source.
// The transmitter is driven with a level send enable (tx_start) that is held
// until the one-cycle byte-sent pulse (tx_done).
//
// Ports:
//   clk         clock
//   rst         synchronous reset, active low
//   req         per-requester byte valid, held until granted
//   req_data    payload bytes, requester i in bits [8i+7:8i]
//   grant       one-hot, one-cycle pulse: payload of requester i captured
//   tx_data     byte presented to the UART transmitter
//   tx_start    UART send enable, held until tx_done
//   tx_done     UART byte-sent pulse
//   busy        high whenever the arbiter is not idle
//   owner       index of the current or last granted requester
//   sent_count  payload bytes completed, wraps at 16 bits
module uart_tx_arbiter #(
  parameter int          NUM_REQ     = 2,
  parameter int          ADD_HEADER  = 1,
  parameter logic [7:0]  HEADER_BASE = 8'hA0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [1:0]           owner,
  output logic [15:0]          sent_count
);

  typedef enum logic [1:0] {
    IDLE,
    SEND_HDR,
    SEND_DATA,
    GAP
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           rr_last;
  logic [1:0]           rr_last_nxt;
  logic [7:0]           payload;
  logic [7:0]           payload_nxt;
  logic [NUM_REQ-1:0]   grant_nxt;
  logic [1:0]           owner_nxt;
  logic [7:0]           tx_data_nxt;
  logic                 tx_start_nxt;
  logic [15:0]          count_nxt;

  // Requests and payloads widened to the four-requester maximum so that a
  // 2-bit index can address them for every legal NUM_REQ.
  logic [3:0]           req_ext;
  logic [31:0]          data_ext;
  logic [3:0]           grant_ext;
  logic [2:0]           pick;
  logic                 pick_found;
  logic [1:0]           pick_idx;

  // Round-robin search starting one past the last owner. Returns
  // {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] s;
    logic       found;
    logic [1:0] win;
    found = 1'b0;
    win   = 2'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      s = {1'b0, last} + 3'(k);
      if (s >= 3'(NUM_REQ)) s = s - 3'(NUM_REQ);
      if (!found && r[s[1:0]]) begin
        found = 1'b1;
        win   = s[1:0];
      end
    end
    return {found, win};
  endfunction

  function automatic logic [7:0] header_byte(input logic [1:0] idx);
    return HEADER_BASE | {6'b0, idx};
  endfunction

  always_comb begin
    req_ext                     = '0;
    req_ext[NUM_REQ-1:0]        = req;
    data_ext                    = '0;
    data_ext[8*NUM_REQ-1:0]     = req_data;
    pick                        = rr_pick(req_ext, rr_last);
    pick_found                  = pick[2];
    pick_idx                    = pick[1:0];
    grant_ext                   = 4'b0001 << pick_idx;
  end

  always_comb begin
    state_nxt    = state;
    rr_last_nxt  = rr_last;
    payload_nxt  = payload;
    grant_nxt    = '0;
    owner_nxt    = owner;
    tx_data_nxt  = tx_data;
    tx_start_nxt = tx_start;
    count_nxt    = sent_count;

    case (state)
      IDLE: begin
        tx_start_nxt = 1'b0;
        if (pick_found) begin
          grant_nxt    = grant_ext[NUM_REQ-1:0];
          owner_nxt    = pick_idx;
          rr_last_nxt  = pick_idx;
          payload_nxt  = data_ext[{pick_idx, 3'b000} +: 8];
          tx_start_nxt = 1'b1;
          if (ADD_HEADER != 0) begin
            state_nxt   = SEND_HDR;
            tx_data_nxt = header_byte(pick_idx);
          end else begin
            state_nxt   = SEND_DATA;
            tx_data_nxt = payload_nxt;
          end
        end
      end

      SEND_HDR: begin
        // Drop tx_start for one cycle between header and payload.
        if (tx_start && tx_done) begin
          state_nxt    = SEND_DATA;
          tx_start_nxt = 1'b0;
          tx_data_nxt  = payload;
        end
      end

      SEND_DATA: begin
        if (!tx_start) begin
          tx_start_nxt = 1'b1;
        end else if (tx_done) begin
          count_nxt    = sent_count + 16'd1;
          tx_start_nxt = 1'b0;
          state_nxt    = GAP;
        end
      end

      GAP: begin
        tx_start_nxt = 1'b0;
        state_nxt    = IDLE;
      end

      default: begin
        tx_start_nxt = 1'b0;
        state_nxt    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      rr_last    <= 2'(NUM_REQ - 1);
      grant      <= '0;
      owner      <= 2'd0;
      tx_data    <= 8'd0;
      tx_start   <= 1'b0;
      sent_count <= 16'd0;
    end else begin
      state      <= state_nxt;
      rr_last    <= rr_last_nxt;
      grant      <= grant_nxt;
      owner      <= owner_nxt;
      tx_data    <= tx_data_nxt;
      tx_start   <= tx_start_nxt;
      sent_count <= count_nxt;
    end
  end

  // Captured payload is pure data and needs no reset.
  always_ff @(posedge clk) begin
    payload <= payload_nxt;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: a two-requester instance with header bytes,
// served by a UART model with random per-byte latency, plus a three-requester
// instance without header bytes driven directly.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req;
  logic [15:0] req_data;
  logic [1:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        busy;
  logic [1:0]  owner;
  logic [15:0] sent_count;

  logic [2:0]  req2;
  logic [23:0] req_data2;
  logic [2:0]  grant2;
  logic [7:0]  tx_data2;
  logic        tx_start2;
  logic        tx_done2;
  logic        busy2;
  logic [1:0]  owner2;
  logic [15:0] sent_count2;

  uart_tx_arbiter #(.NUM_REQ(2), .ADD_HEADER(1), .HEADER_BASE(8'hA0)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done), .busy(busy),
    .owner(owner), .sent_count(sent_count)
  );

  uart_tx_arbiter #(.NUM_REQ(3), .ADD_HEADER(0), .HEADER_BASE(8'hA0)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .req_data(req_data2), .grant(grant2),
    .tx_data(tx_data2), .tx_start(tx_start2), .tx_done(tx_done2), .busy(busy2),
    .owner(owner2), .sent_count(sent_count2)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state and scoreboard queues.
  typedef struct {
    logic [7:0]  b;
    bit          pay;
    logic [15:0] cnt;
  } exp_byte_t;

  exp_byte_t   exp_b[$];
  int          exp_g[$];
  logic [1:0]  last_m;
  logic [15:0] cnt_m;
  logic [7:0]  dat [2];
  logic [1:0]  mask;
  int          hdr_ph;
  int          pay_ph;
  logic [15:0] pay_cnt;
  int          bytes_seen;
  int          tfix;
  bit          spur_en;

  // First requester found searching upward from last+1, wrapping.
  function automatic int rr_model(input logic [1:0] m, input int last);
    for (int k = 1; k <= 2; k++) begin
      int i;
      i = (last + k) % 2;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  task automatic expect_xfer(input int w);
    exp_g.push_back(w);
    exp_b.push_back('{b: 8'hA0 | 8'(w), pay: 1'b0, cnt: 16'h0});
    cnt_m = cnt_m + 16'd1;
    exp_b.push_back('{b: dat[w], pay: 1'b1, cnt: cnt_m});
    last_m = 2'(w);
  endtask

  task automatic drive();
    req      = mask;
    req_data = {dat[1], dat[0]};
  endtask

  // UART model: tx_done after T cycles of tx_start; optional stray pulses
  // while tx_start is low.
  initial begin
    int cnt;
    int tcur;
    cnt     = 0;
    tcur    = 1;
    tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_start) begin
        if (cnt == 0) tcur = (tfix > 0) ? tfix : int'($urandom_range(1, 5));
        cnt++;
        if (cnt >= tcur) begin
          tx_done = 1'b1;
          cnt     = 0;
        end else begin
          tx_done = 1'b0;
        end
      end else begin
        cnt     = 0;
        tx_done = spur_en && ($urandom_range(0, 2) == 0);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT grants or completes a byte.
  initial begin
    int        w;
    exp_byte_t e;
    hdr_ph     = 0;
    pay_ph     = 0;
    bytes_seen = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (hdr_ph == 1) begin
          chk("hdr_gap_tx_start", tx_start, 0);
          chk("hdr_gap_busy", busy, 1);
          hdr_ph = 2;
        end else if (hdr_ph == 2) begin
          chk("payload_tx_start", tx_start, 1);
          hdr_ph = 0;
        end
        if (pay_ph == 1) begin
          chk("sent_count", sent_count, pay_cnt);
          chk("gap_tx_start", tx_start, 0);
          chk("gap_busy", busy, 1);
          pay_ph = 2;
        end else if (pay_ph == 2) begin
          chk("idle_busy", busy, 0);
          pay_ph = 0;
        end
        if (grant != 2'b00) begin
          if (exp_g.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_grant: got %0h expected none at %0t", grant, $time);
          end else begin
            w = exp_g.pop_front();
            chk("grant", grant, 32'(1 << w));
            chk("owner", owner, w);
          end
        end
        if (tx_start && tx_done) begin
          bytes_seen++;
          if (exp_b.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_byte: got %0h expected none at %0t", tx_data, $time);
          end else begin
            e = exp_b.pop_front();
            chk(e.pay ? "tx_payload" : "tx_header", tx_data, e.b);
            if (e.pay) begin
              pay_ph  = 1;
              pay_cnt = e.cnt;
            end else begin
              hdr_ph = 1;
            end
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_grant(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (grant == 2'b00 && k < 500);
    if (grant == 2'b00) chk("grant_timeout", grant, 1);
  endtask

  // n grants; hold=1 keeps req/req_data constant, else random churn after
  // each grant (withdrawal, re-request, data change of the granted source).
  task automatic run(input int n, input logic [1:0] start_mask, input bit hold);
    int w;
    int k;
    int o;
    int done_n;
    wait_idle();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    mask = start_mask;
    if (!hold) for (int i = 0; i < 2; i++) if (mask[i]) dat[i] = 8'($urandom);
    drive();
    w = rr_model(mask, int'(last_m));
    expect_xfer(w);
    wait_grant(k);
    chk("grant_latency", k, 1);
    done_n = 1;
    while (done_n < n) begin
      if (!hold) begin
        o       = 1 - w;
        mask[w] = 1'b0;
        dat[w]  = 8'($urandom);
        if ($urandom_range(0, 1) == 1) mask[w] = 1'b1;
        if (!mask[o] && $urandom_range(0, 2) == 0) begin
          mask[o] = 1'b1;
          dat[o]  = 8'($urandom);
        end
      end
      drive();
      if (mask == 2'b00) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        mask = 2'($urandom_range(1, 3));
        for (int i = 0; i < 2; i++) if (mask[i]) dat[i] = 8'($urandom);
        drive();
        w = rr_model(mask, int'(last_m));
        expect_xfer(w);
        wait_grant(k);
        chk("grant_latency", k, 1);
      end else begin
        w = rr_model(mask, int'(last_m));
        expect_xfer(w);
        wait_grant(k);
      end
      done_n++;
    end
    mask = 2'b00;
    drive();
  endtask

  // One payload-only transfer on the three-requester instance.
  task automatic xfer2(input int idx, input logic [7:0] b, input logic [15:0] c);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (grant2 == 3'b000 && k < 100);
    chk("nh_grant", grant2, 32'(1 << idx));
    chk("nh_owner", owner2, idx);
    req2[idx]             = 1'b0;
    req_data2[8*idx +: 8] = 8'($urandom);
    chk("nh_tx_start", tx_start2, 1);
    chk("nh_tx_data", tx_data2, b);
    repeat (2) @(negedge clk);
    chk("nh_tx_data_hold", tx_data2, b);
    tx_done2 = 1'b1;
    @(negedge clk);
    tx_done2 = 1'b0;
    chk("nh_gap_tx_start", tx_start2, 0);
    chk("nh_count", sent_count2, c);
    chk("nh_gap_busy", busy2, 1);
    @(negedge clk);
    chk("nh_idle_busy", busy2, 0);
    chk("nh_tx_data_kept", tx_data2, b);
  endtask

  initial begin
    int k;
    int n0;
    rst       = 1'b0;
    req       = 2'b00;
    req_data  = 16'h0;
    req2      = 3'b000;
    req_data2 = 24'h0;
    tx_done2  = 1'b0;
    tfix      = 10;
    spur_en   = 1'b0;
    last_m    = 2'd1;
    cnt_m     = 16'd0;
    mask      = 2'b00;
    dat[0]    = 8'h00;
    dat[1]    = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_sent_count", sent_count, 0);
    chk("rst_busy2", busy2, 0);
    rst = 1'b1;
    @(negedge clk);

    // Payload-only instance: requester 1 alone, then 0 and 2 contending.
    req_data2 = {8'h5A, 8'hFF, 8'hC3};
    req2      = 3'b010;
    xfer2(1, 8'hFF, 16'd1);
    req2 = 3'b101;
    xfer2(2, 8'h5A, 16'd2);
    xfer2(0, 8'hC3, 16'd3);

    // Single request, header then payload, T = 10.
    dat[0] = 8'h3C;
    run(1, 2'b01, 1'b1);

    // Randomized traffic with random UART latency and stray tx_done pulses.
    wait_idle();
    tfix    = 0;
    spur_en = 1'b1;
    run(30, 2'($urandom_range(1, 3)), 1'b0);

    // Reset while the payload byte is in flight.
    wait_idle();
    tfix    = 10;
    spur_en = 1'b0;
    mask    = 2'b01;
    dat[0]  = 8'($urandom);
    drive();
    exp_g.push_back(0);
    exp_b.push_back('{b: 8'hA0, pay: 1'b0, cnt: 16'h0});
    last_m = 2'd0;
    n0     = bytes_seen;
    wait_grant(k);
    mask = 2'b00;
    drive();
    k = 0;
    while (bytes_seen == n0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("hdr_done_before_reset", 32'(bytes_seen != n0), 1);
    repeat (3) @(negedge clk);
    chk("pre_reset_tx_start", tx_start, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_tx_start", tx_start, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sent_count", sent_count, 0);
    chk("abort_grant", grant, 0);
    chk("abort_owner", owner, 0);
    chk("abort_tx_data", tx_data, 0);
    hdr_ph = 0;
    pay_ph = 0;
    exp_b.delete();
    exp_g.delete();
    cnt_m  = 16'd0;
    last_m = 2'd1;
    @(negedge clk);
    rst = 1'b1;

    // Contention with both requests held: expected order 0,1,0,1.
    tfix    = 0;
    spur_en = 1'b1;
    dat[0]  = 8'h11;
    dat[1]  = 8'h22;
    run(4, 2'b11, 1'b1);

    // Counter wrap from a preloaded value.
    wait_idle();
    force dut.sent_count = 16'hFFFE;
    @(negedge clk);
    release dut.sent_count;
    cnt_m = 16'hFFFE;
    run(2, 2'b01, 1'b0);

    wait_idle();
    repeat (4) @(negedge clk);
    chk("exp_bytes_drained", exp_b.size(), 0);
    chk("exp_grants_drained", exp_g.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule
